// File: rtl/aes_key_bank.sv
// Multi-slot AES key-schedule bank: expands one word per cycle into per-slot storage.
// Optional macro AES_KEY_BANK_INV_ORDER_EN adds rd_inv for decryption-order reads.

package function_package;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // S-box computed as GF(2^8) inverse (a^254) followed by the AES affine map.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = a;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

endpackage

module aes_key_bank #(
    parameter int NUM_SLOTS = 4,
    parameter int SLOT_W    = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [SLOT_W-1:0] load_slot,
    input  logic [255:0]      load_key,
    input  logic [1:0]        load_klen,
    input  logic [SLOT_W-1:0] rd_slot,
    input  logic [3:0]        rd_round,
`ifdef AES_KEY_BANK_INV_ORDER_EN
    input  logic              rd_inv,
`endif
    output logic [127:0]      rd_key,
    output logic [1:0]        rd_klen,
    output logic              rd_valid,
    output logic              busy
);
    import function_package::*;

    typedef enum logic {IDLE, EXPAND} state_t;

    localparam logic [SLOT_W:0] SLOT_LIMIT = (SLOT_W+1)'(NUM_SLOTS);

    function automatic logic [3:0] nr_of(input logic [1:0] klen);
        return (klen == 2'b11) ? 4'd14 : (klen == 2'b10) ? 4'd12 : 4'd10;
    endfunction

    function automatic logic [2:0] nk_m1_of(input logic [1:0] klen);
        return (klen == 2'b11) ? 3'd7 : (klen == 2'b10) ? 3'd5 : 3'd3;
    endfunction

    state_t            state, state_nxt;
    logic [31:0]       mem [NUM_SLOTS][60];
    logic [1:0]        slot_klen [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] slot_done;

    logic [31:0]       hist [8];   // hist[k] = w[i-1-k]
    logic [SLOT_W-1:0] cur_slot;
    logic [5:0]        cur_idx;
    logic [5:0]        last_idx;
    logic [2:0]        nk_m1;
    logic [2:0]        mod_cnt;
    logic [7:0]        rcon;

    logic              load_fire, expand_en, last_word;
    logic [31:0]       key_w [8];
    logic [7:0]        key_mask;
    logic [31:0]       t_word, new_word;

    assign load_fire = load_valid && load_ready;
    assign expand_en = (state == EXPAND) && !rst;
    assign last_word = (state == EXPAND) && (cur_idx == last_idx);

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // NOTE: every output gets a default first so the block stays combinational.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (load_fire) state_nxt = EXPAND;
            EXPAND:  if (last_word) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        load_ready = (state == IDLE) && !rst;
        busy       = (state == EXPAND);
    end

    // Key words in schedule order: w[0] is the most significant word of the key.
    always_comb begin
        for (int k = 0; k < 8; k++) key_w[k] = '0;
        case (load_klen)
            2'b11: begin
                key_mask = 8'hff;
                for (int k = 0; k < 8; k++) key_w[k] = load_key[32*(7-k) +: 32];
            end
            2'b10: begin
                key_mask = 8'h3f;
                for (int k = 0; k < 6; k++) key_w[k] = load_key[32*(5-k) +: 32];
            end
            default: begin
                key_mask = 8'h0f;
                for (int k = 0; k < 4; k++) key_w[k] = load_key[32*(3-k) +: 32];
            end
        endcase
    end

    always_comb begin
        t_word = hist[0];
        if (mod_cnt == 3'd0)
            t_word = sub_word({hist[0][23:0], hist[0][31:24]}) ^ {rcon, 24'h0};
        else if (nk_m1 == 3'd7 && mod_cnt == 3'd4)
            t_word = sub_word(hist[0]);
        new_word = hist[nk_m1] ^ t_word;
    end

    always_ff @(posedge clk) begin
        if (load_fire) begin
            cur_slot <= load_slot;
            nk_m1    <= nk_m1_of(load_klen);
            cur_idx  <= {3'b000, nk_m1_of(load_klen)} + 6'd1;
            last_idx <= {nr_of(load_klen), 2'b11};
            mod_cnt  <= 3'd0;
            rcon     <= 8'h01;
            for (int k = 0; k < 8; k++) hist[k] <= load_key[32*k +: 32];
        end else if (expand_en) begin
            cur_idx <= cur_idx + 6'd1;
            mod_cnt <= (mod_cnt == nk_m1) ? 3'd0 : mod_cnt + 3'd1;
            if (mod_cnt == 3'd0) rcon <= xtime(rcon);
            hist[0] <= new_word;
            for (int k = 1; k < 8; k++) hist[k] <= hist[k-1];
        end
    end

    // NOTE: key storage has no reset; the per-slot done flag alone gates validity.
    always_ff @(posedge clk) begin
        if (load_fire) begin
            for (int k = 0; k < 8; k++)
                if (key_mask[k]) mem[load_slot][k] <= key_w[k];
        end else if (expand_en) begin
            mem[cur_slot][cur_idx] <= new_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_done <= '0;
            for (int s = 0; s < NUM_SLOTS; s++) slot_klen[s] <= 2'b11;
        end else begin
            if (load_fire) begin
                slot_done[load_slot] <= 1'b0;
                slot_klen[load_slot] <= load_klen;
            end
            if (last_word) slot_done[cur_slot] <= 1'b1;
        end
    end

    logic              rd_slot_ok, rd_hit;
    logic [SLOT_W-1:0] rd_idx;
    logic [3:0]        rd_nr, eff_round, word_round;

    always_comb begin
        rd_slot_ok = ({1'b0, rd_slot} < SLOT_LIMIT);
        rd_idx     = rd_slot_ok ? rd_slot : '0;
        rd_nr      = nr_of(slot_klen[rd_idx]);
        rd_hit     = rd_slot_ok && slot_done[rd_idx] && (rd_round <= rd_nr);
`ifdef AES_KEY_BANK_INV_ORDER_EN
        eff_round  = rd_inv ? (rd_nr - rd_round) : rd_round;
`else
        eff_round  = rd_round;
`endif
        word_round = rd_hit ? eff_round : 4'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_key   <= '0;
            rd_klen  <= 2'b11;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_hit;
            rd_klen  <= rd_slot_ok ? slot_klen[rd_idx] : 2'b11;
            rd_key   <= rd_hit ? {mem[rd_idx][{word_round, 2'b00}], mem[rd_idx][{word_round, 2'b01}],
                                  mem[rd_idx][{word_round, 2'b10}], mem[rd_idx][{word_round, 2'b11}]}
                               : '0;
        end
    end

endmodule
